// File: rtl/branch_resolve_bht_pkg.sv
// Shared encodings and counter constants for the branch resolve / BHT slice.
package branch_resolve_bht_pkg;

    localparam int unsigned IDX_W_DEF = 6;
    localparam int unsigned CNT_W_DEF = 2;
    localparam int unsigned PC_W_DEF  = 32;

    // Saturating counter limits as a function of counter width
    function automatic int unsigned cnt_max(input int unsigned w);
        return (1 << w) - 1;
    endfunction

    function automatic int unsigned cnt_init(input int unsigned w);
        return (1 << (w - 1)) - 1;
    endfunction

    localparam int unsigned CNT_W    = CNT_W_DEF;
    localparam int unsigned CNT_MAX  = (1 << CNT_W) - 1;
    localparam int unsigned CNT_INIT = (1 << (CNT_W - 1)) - 1;

    typedef enum logic [2:0] {
        COND_NONE = 3'b000,
        COND_BEQ  = 3'b001,
        COND_BNE  = 3'b010,
        COND_BLEZ = 3'b011,
        COND_BGTZ = 3'b100,
        COND_BLTZ = 3'b101,
        COND_BGEZ = 3'b110,
        COND_RSVD = 3'b111
    } cond_e;

    typedef enum logic [1:0] {
        JSEL_SEQ  = 2'b00,
        JSEL_RSVD = 2'b01,
        JSEL_J    = 2'b10,
        JSEL_JR   = 2'b11
    } jsel_e;

    typedef enum logic [2:0] {
        PCSRC_SEQ     = 3'b000,
        PCSRC_BR      = 3'b001,
        PCSRC_J       = 3'b010,
        PCSRC_JR      = 3'b011,
        PCSRC_RECOVER = 3'b100
    } pcsrc_e;

endpackage

// File: rtl/branch_resolve_bht_if.sv
// D-stage resolution bus: instruction operands in, redirect decision out.
interface branch_resolve_bht_if #(
    parameter int unsigned PC_W = 32
);
    logic            d_valid;
    logic            d_stall;
    logic [PC_W-1:0] d_pc;
    logic [2:0]      d_cond;
    logic [1:0]      d_jump_sel;
    logic [31:0]     d_rs;
    logic [31:0]     d_rt;
    logic            d_pred_taken;
    logic [2:0]      pcsrc_d;
    logic            mispredict;
    logic            d_taken;

    modport master (
        output d_valid, d_stall, d_pc, d_cond, d_jump_sel, d_rs, d_rt, d_pred_taken,
        input  pcsrc_d, mispredict, d_taken
    );

    modport slave (
        input  d_valid, d_stall, d_pc, d_cond, d_jump_sel, d_rs, d_rt, d_pred_taken,
        output pcsrc_d, mispredict, d_taken
    );
endinterface

// File: rtl/branch_resolve_bht_bht_counter_array.sv
// Table of saturating taken/not-taken counters with one read and one update port.
module bht_counter_array
    import branch_resolve_bht_pkg::*;
#(
    parameter int unsigned IDX_W = 6,
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_pred,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);
    localparam int unsigned      DEPTH    = 1 << IDX_W;
    localparam logic [CNT_W-1:0] SAT_HI   = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] SAT_INIT = CNT_W'(cnt_init(CNT_W));

    logic [CNT_W-1:0] cnt_q [DEPTH];
    logic [CNT_W-1:0] cur_cnt;
    logic [CNT_W-1:0] nxt_cnt;

    // Prediction is the counter MSB; reads see the value before this cycle's update
    assign rd_pred = cnt_q[rd_idx][CNT_W-1];

    // Saturating step for the entry being trained
    always_comb begin
        cur_cnt = cnt_q[wr_idx];
        nxt_cnt = cur_cnt;
        if (wr_taken) begin
            if (cur_cnt != SAT_HI) nxt_cnt = cur_cnt + CNT_W'(1);
        end else begin
            if (cur_cnt != '0) nxt_cnt = cur_cnt - CNT_W'(1);
        end
    end

    // Table storage, cleared to weakly not-taken on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) cnt_q[i] <= SAT_INIT;
        end else if (wr_en) begin
            cnt_q[wr_idx] <= nxt_cnt;
        end
    end
endmodule

// File: rtl/branch_resolve_bht.sv
// Decode-stage branch resolution with fetch-stage BHT lookup.
// Optional BHT_STATS_EN: enables branch / mispredict statistics counters.
module branch_resolve_bht
    import branch_resolve_bht_pkg::*;
#(
    parameter int unsigned IDX_W = IDX_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned PC_W  = PC_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PC_W-1:0]       f_pc,
    output logic                  f_pred_taken,
    branch_resolve_bht_if.slave   d,
    output logic [PC_W-1:0]       stat_branches,
    output logic [PC_W-1:0]       stat_mispredicts
);
    logic   eq;
    logic   rs_neg;
    logic   rs_zero;
    logic   cond_true;
    logic   cond_is_br;
    logic   is_br;
    logic   taken;
    logic   train_en;
    pcsrc_e pcsrc;
    logic   unused_pc_bits;

    bht_counter_array #(
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) u_bht (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (f_pc[IDX_W+1:2]),
        .rd_pred  (f_pred_taken),
        .wr_en    (train_en),
        .wr_idx   (d.d_pc[IDX_W+1:2]),
        .wr_taken (taken)
    );

    // Branch condition evaluation on forwarded operands
    always_comb begin
        eq         = (d.d_rs == d.d_rt);
        rs_neg     = d.d_rs[31];
        rs_zero    = (d.d_rs == 32'd0);
        cond_true  = 1'b0;
        cond_is_br = 1'b1;
        case (cond_e'(d.d_cond))
            COND_BEQ:  cond_true = eq;
            COND_BNE:  cond_true = !eq;
            COND_BLEZ: cond_true = rs_neg | rs_zero;
            COND_BGTZ: cond_true = !rs_neg & !rs_zero;
            COND_BLTZ: cond_true = rs_neg;
            COND_BGEZ: cond_true = !rs_neg;
            default:   cond_is_br = 1'b0;
        endcase
    end

    assign is_br    = d.d_valid & cond_is_br;
    assign taken    = is_br & cond_true;
    assign train_en = is_br & !d.d_stall;

    // Next-PC select: jumps first, then prediction correction
    always_comb begin
        pcsrc = PCSRC_SEQ;
        if (d.d_valid) begin
            if (d.d_jump_sel == JSEL_J)                       pcsrc = PCSRC_J;
            else if (d.d_jump_sel == JSEL_JR)                 pcsrc = PCSRC_JR;
            else if (is_br & taken & !d.d_pred_taken)         pcsrc = PCSRC_BR;
            else if (is_br & !taken & d.d_pred_taken)         pcsrc = PCSRC_RECOVER;
        end
    end

    assign d.pcsrc_d    = pcsrc;
    assign d.mispredict = (pcsrc == PCSRC_BR) || (pcsrc == PCSRC_RECOVER);
    assign d.d_taken    = taken;

    // PC bits outside the table index are not needed
    assign unused_pc_bits = ^{f_pc[PC_W-1:IDX_W+2], f_pc[1:0],
                              d.d_pc[PC_W-1:IDX_W+2], d.d_pc[1:0]};

`ifdef BHT_STATS_EN
    // Saturating counts of trained branches and trained mispredicts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (train_en) begin
            if (stat_branches != '1) stat_branches <= stat_branches + PC_W'(1);
            if (d.mispredict && (stat_mispredicts != '1))
                stat_mispredicts <= stat_mispredicts + PC_W'(1);
        end
    end
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_bht.sv
// Scoreboard bench for branch_resolve_bht: driver queues expectations, negedge monitor checks.
module tb_branch_resolve_bht;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] f_pc = 32'h0;
    logic        f_pred_taken;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    int checks = 0;
    int failures = 0;
    int tally_br = 0;
    int tally_mis = 0;

    typedef struct {
        string       name;
        logic        fpred;
        logic        taken;
        logic [2:0]  pcsrc;
        logic        mis;
        logic [31:0] sbr;
        logic [31:0] smis;
    } exp_t;

    exp_t q[$];

    branch_resolve_bht_if #(.PC_W(32)) dif();

    branch_resolve_bht dut (
        .clk              (clk),
        .reset            (reset),
        .f_pc             (f_pc),
        .f_pred_taken     (f_pred_taken),
        .d                (dif),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk({e.name, ".f_pred"},   32'(f_pred_taken),   32'(e.fpred));
            chk({e.name, ".d_taken"},  32'(dif.d_taken),    32'(e.taken));
            chk({e.name, ".pcsrc"},    32'(dif.pcsrc_d),    32'(e.pcsrc));
            chk({e.name, ".mispred"},  32'(dif.mispredict), 32'(e.mis));
            chk({e.name, ".stat_br"},  stat_branches,       e.sbr);
            chk({e.name, ".stat_mis"}, stat_mispredicts,    e.smis);
        end
    end

    // Driver: apply one vector just after the rising edge and queue its expectation
    task automatic vec(input string name, input logic rst, input logic valid, input logic stall,
                       input logic [31:0] pc, input logic [2:0] cond, input logic [1:0] jsel,
                       input logic [31:0] rs, input logic [31:0] rt, input logic pred,
                       input logic [31:0] fpc, input logic ef, input logic et,
                       input logic [2:0] ep, input logic em);
        exp_t e;
        @(posedge clk);
        #1;
        reset            = rst;
        dif.d_valid      = valid;
        dif.d_stall      = stall;
        dif.d_pc         = pc;
        dif.d_cond       = cond;
        dif.d_jump_sel   = jsel;
        dif.d_rs         = rs;
        dif.d_rt         = rt;
        dif.d_pred_taken = pred;
        f_pc             = fpc;
        if (rst) begin
            tally_br  = 0;
            tally_mis = 0;
        end
        e.name  = name;
        e.fpred = ef;
        e.taken = et;
        e.pcsrc = ep;
        e.mis   = em;
`ifdef BHT_STATS_EN
        e.sbr   = 32'(tally_br);
        e.smis  = 32'(tally_mis);
`else
        e.sbr   = 32'h0;
        e.smis  = 32'h0;
`endif
        q.push_back(e);
        if (!rst && valid && !stall && cond >= 3'd1 && cond <= 3'd6) begin
            tally_br++;
            if (em) tally_mis++;
        end
    endtask

    task automatic idle(input string name, input logic [31:0] fpc, input logic ef);
        vec(name, 1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 2'd0, 32'h0, 32'h0, 1'b0, fpc, ef, 1'b0, 3'd0, 1'b0);
    endtask

    initial begin
        dif.d_valid = 1'b0; dif.d_stall = 1'b0; dif.d_pc = '0; dif.d_cond = '0;
        dif.d_jump_sel = '0; dif.d_rs = '0; dif.d_rt = '0; dif.d_pred_taken = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state and first training
        vec("rst_hold", 1, 0, 0, 32'h0, 3'd0, 2'd0, 0, 0, 0, 32'h3000, 0, 0, 3'd0, 0);
        idle("after_rst", 32'h3000, 0);
        vec("beq_t_p0", 0, 1, 0, 32'h3000, 3'd1, 2'd0, 5, 5, 0, 32'h3000, 0, 1, 3'd1, 1);
        idle("f_after_inc", 32'h3000, 1);
        for (int i = 0; i < 4; i++)
            vec("beq_t_p1", 0, 1, 0, 32'h3000, 3'd1, 2'd0, 5, 5, 1, 32'h3000, 1, 1, 3'd0, 0);
        vec("bne_nt_p1_a", 0, 1, 0, 32'h3000, 3'd2, 2'd0, 5, 5, 1, 32'h3000, 1, 0, 3'd4, 1);
        idle("f_sat_dec1", 32'h3000, 1);
        vec("bne_nt_p1_b", 0, 1, 0, 32'h3000, 3'd2, 2'd0, 5, 5, 1, 32'h3000, 1, 0, 3'd4, 1);
        idle("f_sat_dec2", 32'h3000, 0);

        // Sign/zero condition sweep
        vec("blez_m1", 0, 1, 0, 32'h4004, 3'd3, 2'd0, 32'hFFFF_FFFF, 0, 0, 32'h3000, 0, 1, 3'd1, 1);
        vec("bgtz_m1", 0, 1, 0, 32'h4004, 3'd4, 2'd0, 32'hFFFF_FFFF, 0, 0, 32'h3000, 0, 0, 3'd0, 0);
        vec("bltz_m1", 0, 1, 0, 32'h4004, 3'd5, 2'd0, 32'hFFFF_FFFF, 0, 0, 32'h3000, 0, 1, 3'd1, 1);
        vec("bgez_m1", 0, 1, 0, 32'h4004, 3'd6, 2'd0, 32'hFFFF_FFFF, 0, 0, 32'h3000, 0, 0, 3'd0, 0);
        vec("blez_0",  0, 1, 0, 32'h4004, 3'd3, 2'd0, 0, 0, 0, 32'h3000, 0, 1, 3'd1, 1);
        vec("bgtz_0",  0, 1, 0, 32'h4004, 3'd4, 2'd0, 0, 0, 0, 32'h3000, 0, 0, 3'd0, 0);
        vec("bltz_0",  0, 1, 0, 32'h4004, 3'd5, 2'd0, 0, 0, 0, 32'h3000, 0, 0, 3'd0, 0);
        vec("bgez_0",  0, 1, 0, 32'h4004, 3'd6, 2'd0, 0, 0, 0, 32'h3000, 0, 1, 3'd1, 1);
        vec("bne_t",   0, 1, 0, 32'h5008, 3'd2, 2'd0, 1, 2, 0, 32'h3000, 0, 1, 3'd1, 1);
        vec("beq_nt",  0, 1, 0, 32'h5008, 3'd1, 2'd0, 1, 2, 0, 32'h3000, 0, 0, 3'd0, 0);

        // Reserved condition must not train
        vec("beq_t_4004", 0, 1, 0, 32'h4004, 3'd1, 2'd0, 7, 7, 0, 32'h4004, 0, 1, 3'd1, 1);
        vec("cond_rsvd",  0, 1, 0, 32'h4004, 3'd7, 2'd0, 7, 7, 1, 32'h4004, 1, 0, 3'd0, 0);
        idle("f_after_rsvd", 32'h4004, 1);

        // Jump selection and priority
        vec("jr_over_beq", 0, 1, 0, 32'h600C, 3'd1, 2'd3, 3, 3, 0, 32'h3000, 0, 1, 3'd3, 0);
        vec("j",           0, 1, 0, 32'h600C, 3'd0, 2'd2, 3, 3, 0, 32'h3000, 0, 0, 3'd2, 0);
        vec("jsel_rsvd",   0, 1, 0, 32'h600C, 3'd0, 2'd1, 3, 3, 0, 32'h3000, 0, 0, 3'd0, 0);
        vec("invalid_j",   0, 0, 0, 32'h600C, 3'd1, 2'd2, 3, 3, 0, 32'h3000, 0, 0, 3'd0, 0);

        // Stalled branch trains exactly once
        for (int i = 0; i < 3; i++)
            vec("beq_stall", 0, 1, 1, 32'h7010, 3'd1, 2'd0, 9, 9, 0, 32'h7010, 0, 1, 3'd1, 1);
        vec("beq_release", 0, 1, 0, 32'h7010, 3'd1, 2'd0, 9, 9, 0, 32'h7010, 0, 1, 3'd1, 1);
        idle("f_after_stall", 32'h7010, 1);
        vec("bne_nt_7010", 0, 1, 0, 32'h7010, 3'd2, 2'd0, 9, 9, 1, 32'h7010, 1, 0, 3'd4, 1);
        idle("f_single_inc", 32'h7010, 0);

        // Asynchronous reset between edges
        idle("pre_reset", 32'h4004, 1);
        vec("async_reset", 1, 0, 0, 32'h0, 3'd0, 2'd0, 0, 0, 0, 32'h4004, 0, 0, 3'd0, 0);
        idle("post_reset", 32'h4004, 0);
        vec("beq_post_rst", 0, 1, 0, 32'h4004, 3'd1, 2'd0, 4, 4, 0, 32'h4004, 0, 1, 3'd1, 1);
        idle("f_post_rst_inc", 32'h4004, 1);

        repeat (2) @(posedge clk);
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/branch_resolve_bht.md
Name: branch_resolve_bht

Overview:
- Decode-stage branch resolution unit for the pipelined MIPS core, with a fetch-stage branch history table (BHT).
- F stage gets a taken/not-taken prediction per PC. D stage resolves six branch conditions on forwarded operands and drives the next-PC select. It flags a mispredict when the resolved outcome differs from the prediction.
- BHT entries are saturating counters, trained on every resolved, non-stalled branch.

Parameters:
- IDX_W, 6, BHT index width; 2**IDX_W entries, index = pc[IDX_W+1:2]
- CNT_W, 2, counter width per entry (>=2); prediction = counter MSB
- PC_W, 32, program counter width

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high; clears the BHT and all state
- f_pc  in  PC_W  fetch PC for lookup
- f_pred_taken  out  1  prediction for f_pc (combinational table read)
- d_valid  in  1  D-stage instruction valid
- d_stall  in  1  D stage held this cycle
- d_pc  in  PC_W  PC of the D-stage instruction
- d_cond  in  3  000 none, 001 beq, 010 bne, 011 blez, 100 bgtz, 101 bltz, 110 bgez, 111 reserved (treated as none)
- d_jump_sel  in  2  00 sequential, 10 j/jal, 11 jr; 01 reserved (treated as 00)
- d_rs, d_rt  in  32  forwarded operands
- d_pred_taken  in  1  prediction carried down the pipe with the instruction
- pcsrc_d  out  3  000 no redirect, 001 branch target, 010 jump target, 011 jr target, 100 recover to d_pc+8
- mispredict  out  1  redirect due to wrong prediction; F/D flush request
- d_taken  out  1  resolved branch outcome

Behaviour:
- Reset (async, immediate):
  - every BHT entry = 2**(CNT_W-1)-1, i.e. weakly not taken
  - f_pred_taken follows the table and reads 0 during and after reset
- Lookup: f_pred_taken = bht[f_pc[IDX_W+1:2]][CNT_W-1], combinational, zero latency.
- Resolution (combinational on D inputs):
  - eq = (d_rs == d_rt); sign and zero tests are on d_rs as signed 32-bit
  - d_taken = d_valid & condition true; d_taken = 0 for cond 000/111
- is_br = d_valid & d_cond in 001..110.
- pcsrc_d priority:
  - !d_valid → 000
  - jump_sel 10 → 010; jump_sel 11 → 011 (jump wins if cond is also set)
  - is_br & d_taken & !d_pred_taken → 001
  - is_br & !d_taken & d_pred_taken → 100
  - else → 000
- mispredict = pcsrc_d in {001, 100}. Outputs stay asserted while stalled; the consumer acts only when !d_stall.
- Training:
  - Condition: is_br & !d_stall, at the rising edge of clk.
  - Counter at d_pc's index: taken → +1 saturating at 2**CNT_W-1; not taken → -1 saturating at 0.
  - One update per instruction: stalled cycles never train, so there is no double count.
- Same-index read and write in one cycle: f_pred_taken returns the pre-update value; the new value is visible the next cycle.
- Aliasing between PCs sharing an index is permitted; there are no tags.
- Reset mid-operation: table cleared immediately. Outputs are combinational and track inputs only.

Optional Feature:
- BHT_STATS_EN defined:
  - Two PC_W-bit saturating counters, stat_branches and stat_mispredicts.
  - Increment under the training condition (stat_mispredicts additionally needs mispredict); cleared by reset.
  - Exposed as output ports of the same names.
- Not defined: the ports still exist, tied to 0, and no counter flops are synthesised.

Decomposition:
- Shared package (or `define header in this codebase): d_cond codes, d_jump_sel codes, pcsrc_d codes.
- The same header holds the CNT_W-derived constants: CNT_MAX, CNT_INIT.
- One sub-module: bht_counter_array. It holds the 2**IDX_W x CNT_W reg array, the async reset loop, the read port, and the saturating update port.
- Condition evaluation and pcsrc priority stay in the top module.

Test Plan:
- Reset, then f_pc=0x3000: f_pred_taken=0. beq with rs=rt=5, d_pred_taken=0 → d_taken=1, pcsrc_d=001, mispredict=1. Next cycle f_pred_taken at 0x3000 = 1 (counter 01→10).
- Train the same PC taken 4x → counter saturates at 3. Then bne with rs=rt, pred=1 → pcsrc_d=100, mispredict=1. Counter goes 3→2 and the prediction stays 1.
- Condition sweep with rs=0xFFFFFFFF and rs=0, rt=0 (blez, bgtz, bltz, bgez): d_taken = 1,0,1,0 for rs=-1 and 1,0,0,1 for rs=0. cond=111 → d_taken=0, pcsrc_d=000, no training.
- jr with d_cond=001 and taken → pcsrc_d=011, mispredict=0.
- Hold a taken beq under d_stall=1 for 3 cycles, then release → exactly one counter increment.
- Assert reset asynchronously between edges after training → all entries read 0 immediately. With BHT_STATS_EN, 5 branches including 2 mispredicts → stat_branches=5, stat_mispredicts=2; both read 0 after reset.
